// File: rtl/fifo.sv
// Single-clock FIFO with registered read data.
// empty/full derive combinationally from the occupancy counter.
module fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wenable,
  input  logic                  renable,
  input  logic [FIFO_WIDTH-1:0] wdata,
  output logic                  empty,
  output logic                  full,
  output logic [FIFO_WIDTH-1:0] rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]         ptr_write;
  logic [AW-1:0]         ptr_read;
  logic [AW:0]           count;
  logic [AW:0]           count_d;
  logic [FIFO_WIDTH-1:0] rdata_q;

  logic do_wr;
  logic do_rd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign rdata = rdata_q;

  assign do_wr = wenable & ~full;
  assign do_rd = renable & ~empty;

  // next occupancy: a simultaneous push and pop cancel out
  always_comb begin
    count_d = count;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count + (AW+1)'(1);
      2'b01:   count_d = count - (AW+1)'(1);
      default: count_d = count;
    endcase
  end

  // storage is never cleared; reset only blocks a pending write
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[ptr_write] <= wdata;
    end
  end

  // pointers, occupancy and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_write <= '0;
      ptr_read  <= '0;
      count     <= '0;
      rdata_q   <= '0;
    end else begin
      count <= count_d;
      if (do_wr) begin
        ptr_write <= ptr_write + AW'(1);
      end
      if (do_rd) begin
        rdata_q  <= mem[ptr_read];
        ptr_read <= ptr_read + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, under/overflow, wrap,
// concurrent access and mid-stream reset.
module tb_fifo;

  logic       clk;
  logic       rst;
  logic       wenable;
  logic       renable;
  logic [7:0] wdata;
  logic       empty;
  logic       full;
  logic [7:0] rdata;

  int vec_cnt;
  int err_cnt;

  fifo #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wenable(wenable),
    .renable(renable),
    .wdata  (wdata),
    .empty  (empty),
    .full   (full),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wenable = 1'b1;
    wdata   = d;
    tick();
    wenable = 1'b0;
  endtask

  task automatic pop();
    renable = 1'b1;
    tick();
    renable = 1'b0;
  endtask

  task automatic both(input logic [7:0] d);
    wenable = 1'b1;
    renable = 1'b1;
    wdata   = d;
    tick();
    wenable = 1'b0;
    renable = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b1;
    wenable = 1'b0;
    renable = 1'b0;
    wdata   = 8'h00;

    tick();
    rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_ptr_read", 32'(dut.ptr_read), 32'd0);

    pop();
    chk("uf_empty", 32'(empty), 32'd1);
    chk("uf_full", 32'(full), 32'd0);
    chk("uf_ptr_read", 32'(dut.ptr_read), 32'd0);
    chk("uf_rdata", 32'(rdata), 32'h00);

    push(8'hCA);
    chk("one_empty", 32'(empty), 32'd0);
    chk("one_full", 32'(full), 32'd0);
    pop();
    chk("one_rdata", 32'(rdata), 32'hCA);
    chk("one_empty2", 32'(empty), 32'd1);
    chk("one_full2", 32'(full), 32'd0);

    for (int i = 0; i < 16; i++) begin
      push(8'hF0 + 8'(i));
      chk("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    chk("fill_empty", 32'(empty), 32'd0);
    push(8'hBC);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(dut.count), 32'd16);

    for (int i = 0; i < 16; i++) begin
      pop();
      chk("drain_rdata", 32'(rdata), 32'hF0 + 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_full", 32'(full), 32'd0);
    chk("wrap_ptr_read", 32'(dut.ptr_read), 32'd1);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    both(8'h44);
    chk("rw3_count", 32'(dut.count), 32'd3);
    chk("rw3_rdata", 32'(rdata), 32'h11);

    for (int i = 0; i < 13; i++) begin
      push(8'h50 + 8'(i));
    end
    chk("rwf_pre_full", 32'(full), 32'd1);
    both(8'hEE);
    chk("rwf_full", 32'(full), 32'd0);
    chk("rwf_count", 32'(dut.count), 32'd15);
    chk("rwf_rdata", 32'(rdata), 32'h22);

    pop();
    chk("rwf_seq0", 32'(rdata), 32'h33);
    pop();
    chk("rwf_seq1", 32'(rdata), 32'h44);
    for (int i = 0; i < 13; i++) begin
      pop();
      chk("rwf_seq", 32'(rdata), 32'h50 + 32'(i));
    end
    chk("rwf_empty", 32'(empty), 32'd1);

    both(8'h99);
    chk("rwe_empty", 32'(empty), 32'd0);
    chk("rwe_count", 32'(dut.count), 32'd1);
    chk("rwe_rdata", 32'(rdata), 32'h5C);

    push(8'h98);
    rst     = 1'b1;
    wenable = 1'b1;
    renable = 1'b1;
    wdata   = 8'h77;
    tick();
    rst     = 1'b0;
    wenable = 1'b0;
    renable = 1'b0;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_rdata", 32'(rdata), 32'h00);
    chk("mrst_ptr_read", 32'(dut.ptr_read), 32'd0);

    push(8'hA5);
    pop();
    chk("post_rdata", 32'(rdata), 32'hA5);
    chk("post_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
